cfg_ctrl_feeder: RTL and testbench

- Upstream feeder for the CC_CFG_CTRL configuration-control primitive.
- Accepts a configuration bitstream as a valid/ready byte stream and buffers it in a small FIFO.
- Drives the primitive's DATA/EN/VALID/RECFG inputs with correct sequencing: EN setup time, one-cycle VALID pulses with guard gaps, and an optional trailing RECFG pulse.
- Reports BUSY/DONE/ERR status to the host logic.

---
 rtl/cfg_ctrl_pkg.sv | 24 ++
 rtl/cfg_ctrl_feeder_if.sv | 11 +
 rtl/cfg_byte_fifo.sv | 65 ++++++
 rtl/cfg_ctrl_feeder.sv | 179 +++++++++++++++++
 tb/tb_cfg_ctrl_feeder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_ctrl_pkg.sv
// Shared types and default timing constants for the CC_CFG_CTRL feeder.
package cfg_ctrl_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned EN_SETUP_DEF   = 4;
    localparam int unsigned GAP_CYCLES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF    = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_GAP,
        ST_RECFG,
        ST_FINISH,
        ST_ABORT
    } state_e;

    // States in which the primitive's EN input must be held high.
    function automatic logic en_active(input state_e s);
        return s inside {ST_SETUP, ST_WAIT, ST_GAP, ST_RECFG};
    endfunction

endpackage

// File: rtl/cfg_ctrl_feeder_if.sv
// Byte-stream valid/ready channel from host logic into the feeder.
interface cfg_ctrl_feeder_if import cfg_ctrl_pkg::*; ();

    logic [BYTE_W-1:0] S_DATA;
    logic              S_VALID;
    logic              S_READY;

    modport master (output S_DATA, output S_VALID, input S_READY);
    modport slave  (input S_DATA, input S_VALID, output S_READY);

endinterface

// File: rtl/cfg_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty flags and a flush input.
module cfg_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok;
    logic          pop_ok;

    // A push coinciding with a flush is dropped along with the contents.
    always_comb begin
        push_ok = push_i && !full_q && !flush_i;
        pop_ok  = pop_i && !empty_q;
        wptr_d  = wptr_q + PW'(push_ok);
        rptr_d  = rptr_q + PW'(pop_ok);
        if (flush_i) begin
            rptr_d = wptr_q;
        end
        full_d  = (wptr_d - rptr_d) == PW'(DEPTH);
        empty_d = (wptr_d == rptr_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/cfg_ctrl_feeder.sv
// Sequences a buffered configuration bitstream onto the CC_CFG_CTRL
// DATA/EN/VALID/RECFG inputs and reports session status.
module cfg_ctrl_feeder import cfg_ctrl_pkg::*; #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned EN_SETUP   = EN_SETUP_DEF,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int unsigned LEN_W      = 24,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [LEN_W-1:0]  LEN,
    input  logic              RECFG_REQ,
    cfg_ctrl_feeder_if.slave  s_if,
    output logic [BYTE_W-1:0] CFG_DATA,
    output logic              CFG_EN,
    output logic              CFG_VALID,
    output logic              CFG_RECFG,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int unsigned SW = $clog2(EN_SETUP + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              recfg_flag_q, recfg_flag_d;
    logic [SW-1:0]     setup_cnt_q, setup_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [BYTE_W-1:0] cfg_data_q, cfg_data_d;
    logic              cfg_en_q, cfg_en_d;
    logic              cfg_valid_q, cfg_valid_d;
    logic              cfg_recfg_q, cfg_recfg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              pop;
    logic              fifo_flush;
    logic              fifo_full;
    logic              fifo_empty;
    logic [BYTE_W-1:0] fifo_rdata;

    assign fifo_flush = (state_q == ST_ABORT);

    cfg_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (s_if.S_VALID),
        .wdata_i (s_if.S_DATA),
        .pop_i   (pop),
        .flush_i (fifo_flush),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign s_if.S_READY = !fifo_full;

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        recfg_flag_d = recfg_flag_q;
        setup_cnt_d  = setup_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        to_cnt_d     = to_cnt_q;
        cfg_data_d   = cfg_data_q;
        err_d        = err_q;
        pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    err_d        = 1'b0;
                    rem_d        = LEN;
                    recfg_flag_d = RECFG_REQ;
                    setup_cnt_d  = '0;
                    to_cnt_d     = '0;
                    state_d      = (LEN != '0) ? ST_SETUP : ST_FINISH;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == SW'(EN_SETUP - 1)) begin
                    state_d = ST_WAIT;
                end else begin
                    setup_cnt_d = setup_cnt_q + SW'(1);
                end
            end
            ST_WAIT: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    cfg_data_d = fifo_rdata;
                    rem_d      = rem_q - LEN_W'(1);
                    to_cnt_d   = '0;
                    gap_cnt_d  = '0;
                    state_d    = ST_GAP;
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_ABORT;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ST_GAP: begin
                // The guard gap only protects a following pop, so the last byte exits at once.
                if (rem_q == '0) begin
                    state_d = recfg_flag_q ? ST_RECFG : ST_FINISH;
                end else if (gap_cnt_q == GW'(GAP_CYCLES)) begin
                    state_d = ST_WAIT;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            ST_RECFG:  state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            ST_ABORT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (state_d == ST_ABORT) begin
            err_d = 1'b1;
        end

        cfg_en_d    = en_active(state_d);
        cfg_valid_d = pop;
        cfg_recfg_d = (state_d == ST_RECFG);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FINISH) || (state_d == ST_ABORT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            recfg_flag_q <= 1'b0;
            setup_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            to_cnt_q     <= '0;
            cfg_data_q   <= '0;
            cfg_en_q     <= 1'b0;
            cfg_valid_q  <= 1'b0;
            cfg_recfg_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            recfg_flag_q <= recfg_flag_d;
            setup_cnt_q  <= setup_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            to_cnt_q     <= to_cnt_d;
            cfg_data_q   <= cfg_data_d;
            cfg_en_q     <= cfg_en_d;
            cfg_valid_q  <= cfg_valid_d;
            cfg_recfg_q  <= cfg_recfg_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign CFG_DATA  = cfg_data_q;
    assign CFG_EN    = cfg_en_q;
    assign CFG_VALID = cfg_valid_q;
    assign CFG_RECFG = cfg_recfg_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_cfg_ctrl_feeder.sv
// Directed self-checking bench for cfg_ctrl_feeder with a byte scoreboard.
module tb_cfg_ctrl_feeder;
    import cfg_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [23:0] LEN = '0;
    logic        RECFG_REQ = 1'b0;
    logic [7:0]  CFG_DATA;
    logic        CFG_EN, CFG_VALID, CFG_RECFG, BUSY, DONE, ERR;

    cfg_ctrl_feeder_if s_if ();

    cfg_ctrl_feeder dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .LEN       (LEN),
        .RECFG_REQ (RECFG_REQ),
        .s_if      (s_if),
        .CFG_DATA  (CFG_DATA),
        .CFG_EN    (CFG_EN),
        .CFG_VALID (CFG_VALID),
        .CFG_RECFG (CFG_RECFG),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int vcount = 0;
    int rcount = 0;
    int last_valid_cyc = 0;
    int recfg_cyc = 0;
    logic [7:0] exp_q [$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard consumer and protocol invariants on every delivered pulse.
    always @(negedge CLK) begin
        if (!RST) begin
            if (CFG_VALID) begin
                vcount++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) check("cfg_data_unexpected", 32'(CFG_DATA), 32'hFFFF_FFFF);
                else check("cfg_data", 32'(CFG_DATA), 32'(exp_q.pop_front()));
                check("valid_with_en", 32'(CFG_EN), 1);
                check("valid_not_recfg", 32'(CFG_RECFG), 0);
            end
            if (CFG_RECFG) begin
                rcount++;
                recfg_cyc = cyc;
                check("recfg_with_en", 32'(CFG_EN), 1);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        bit ok = 1'b0;
        s_if.S_DATA  = b;
        s_if.S_VALID = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (s_if.S_READY) begin
                @(posedge CLK);
                exp_q.push_back(b);
                ok = 1'b1;
            end
            @(negedge CLK);
        end
        s_if.S_VALID = 1'b0;
        check("push_accepted", 32'(ok), 1);
    endtask

    // Returns at the negedge of cycle 1 (START sampled at edge 0).
    task automatic start_session(input int len, input logic rq);
        START     = 1'b1;
        LEN       = 24'(len);
        RECFG_REQ = rq;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            if (DONE) begin
                dc = cyc;
                break;
            end
            @(negedge CLK);
        end
        check("done_seen", 32'(DONE), 1);
    endtask

    initial begin
        int dc;
        int vb;
        int rb;
        int seen;
        bit got;

        s_if.S_DATA  = '0;
        s_if.S_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_cfg_en", 32'(CFG_EN), 0);
        check("rst_cfg_valid", 32'(CFG_VALID), 0);
        check("rst_cfg_recfg", 32'(CFG_RECFG), 0);
        check("rst_cfg_data", 32'(CFG_DATA), 0);
        check("rst_busy_done_err", 32'({BUSY, DONE, ERR}), 0);
        check("rst_s_ready", 32'(s_if.S_READY), 1);
        RST = 1'b0;
        @(negedge CLK);

        // Test 1: prefilled three bytes, exact pulse timing.
        push_byte(8'hA5);
        push_byte(8'h5A);
        push_byte(8'hFF);
        rb = rcount;
        vb = vcount;
        start_session(3, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            check($sformatf("t1_en_c%0d", k), 32'(CFG_EN), 32'(k <= 14));
            check($sformatf("t1_valid_c%0d", k), 32'(CFG_VALID), 32'(k == 6 || k == 10 || k == 14));
            check($sformatf("t1_done_c%0d", k), 32'(DONE), 32'(k == 15));
            check($sformatf("t1_busy_c%0d", k), 32'(BUSY), 1);
            @(negedge CLK);
        end
        check("t1_idle_busy", 32'(BUSY), 0);
        check("t1_err", 32'(ERR), 0);
        check("t1_no_recfg", 32'(rcount - rb), 0);
        check("t1_vcount", 32'(vcount - vb), 3);

        // Test 2: streamed data with trailing RECFG.
        rb = rcount;
        vb = vcount;
        start_session(2, 1'b1);
        push_byte(8'h11);
        push_byte(8'h22);
        wait_done(200, dc);
        check("t2_en_at_done", 32'(CFG_EN), 0);
        check("t2_vcount", 32'(vcount - vb), 2);
        check("t2_recfg_count", 32'(rcount - rb), 1);
        check("t2_recfg_before_done", 32'(dc - recfg_cyc), 1);
        @(negedge CLK);

        // Test 3: starvation timeout.
        vb = vcount;
        start_session(4, 1'b0);
        push_byte(8'h3C);
        push_byte(8'hC3);
        wait_done(3000, dc);
        check("t3_err", 32'(ERR), 1);
        check("t3_en_at_done", 32'(CFG_EN), 0);
        check("t3_vcount", 32'(vcount - vb), 2);
        check("t3_timeout_delay", 32'(dc - last_valid_cyc), 32'(GAP_CYCLES_DEF + 1 + TIMEOUT_DEF));
        @(negedge CLK);
        check("t3_s_ready", 32'(s_if.S_READY), 1);
        check("t3_err_sticky", 32'(ERR), 1);
        check("t3_idle", 32'(BUSY), 0);
        start_session(1, 1'b0);
        check("t3_err_cleared", 32'(ERR), 0);
        push_byte(8'h77);
        wait_done(200, dc);
        @(negedge CLK);

        // Test 4: fill to capacity, 17th byte held until a pop frees space.
        for (int i = 0; i < 16; i++) push_byte(8'(8'h40 + i));
        check("t4_full", 32'(s_if.S_READY), 0);
        s_if.S_DATA  = 8'h99;
        s_if.S_VALID = 1'b1;
        repeat (3) @(negedge CLK);
        check("t4_held", 32'(s_if.S_READY), 0);
        vb = vcount;
        start_session(16, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (s_if.S_READY) begin
                @(posedge CLK);
                exp_q.push_back(8'h99);
                got = 1'b1;
            end
            @(negedge CLK);
        end
        s_if.S_VALID = 1'b0;
        check("t4_17th_accepted", 32'(got), 1);
        wait_done(300, dc);
        check("t4_vcount", 32'(vcount - vb), 16);
        check("t4_retained", 32'(exp_q.size()), 1);
        @(negedge CLK);
        start_session(1, 1'b0);
        wait_done(100, dc);
        check("t4_retained_delivered", 32'(exp_q.size()), 0);
        @(negedge CLK);

        // Test 5: zero-length session, second START while busy ignored.
        vb = vcount;
        rb = rcount;
        start_session(0, 1'b0);
        check("t5_done", 32'(DONE), 1);
        check("t5_busy", 32'(BUSY), 1);
        check("t5_en", 32'(CFG_EN), 0);
        START = 1'b1;
        LEN   = 24'd3;
        @(negedge CLK);
        START = 1'b0;
        check("t5_done_one_cycle", 32'(DONE), 0);
        repeat (4) @(negedge CLK);
        check("t5_start_ignored", 32'({BUSY, CFG_EN}), 0);
        check("t5_no_pulses", 32'((vcount - vb) + (rcount - rb)), 0);

        // Test 6: asynchronous reset in the gap after byte 2 of 5.
        for (int i = 0; i < 5; i++) push_byte(8'(8'hE0 + i));
        rb = rcount;
        start_session(5, 1'b1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (CFG_VALID) seen++;
            if (seen == 2) break;
            @(negedge CLK);
        end
        check("t6_reached_byte2", 32'(seen), 2);
        #2 RST = 1'b1;
        #1;
        check("t6_async_en", 32'(CFG_EN), 0);
        check("t6_async_valid_recfg", 32'({CFG_VALID, CFG_RECFG}), 0);
        check("t6_async_data", 32'(CFG_DATA), 0);
        check("t6_async_busy", 32'(BUSY), 0);
        check("t6_async_s_ready", 32'(s_if.S_READY), 1);
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        vb = vcount;
        repeat (10) @(negedge CLK);
        check("t6_stay_idle", 32'({BUSY, CFG_EN}), 0);
        check("t6_no_recfg", 32'(rcount - rb), 0);
        start_session(1, 1'b0);
        wait_done(1200, dc);
        check("t6_fifo_was_empty", 32'(ERR), 1);
        check("t6_no_bytes", 32'(vcount - vb), 0);
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
